// File: rtl/dbg_trace_reader.sv
// Trace RAM readout engine: stops the DMA debug recorder, reads each trace word and
// streams its 40-bit entries (optionally dropping empty ones) on a valid/ready port.
module dbg_trace_reader #(
    parameter int DATA_WIDTH     = 256,
    parameter int DBG_ADDR_WIDTH = 10,
    parameter int ENTRY_BITS     = 40,
    parameter int RD_LAT         = 2,
    parameter int SKIP_EMPTY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      abort,
    input  logic [DBG_ADDR_WIDTH-1:0] start_addr,
    input  logic [DBG_ADDR_WIDTH:0]   word_count,
    output logic                      busy,
    output logic                      done,
    output logic [DBG_ADDR_WIDTH+3:0] entries_sent,
    output logic                      dbg_cmd_valid,
    output logic [5:0]                dbg_cmd,
    output logic                      dbg_re,
    output logic [DBG_ADDR_WIDTH-1:0] dbg_addr,
    input  logic [DATA_WIDTH-1:0]     dbg_dout,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [ENTRY_BITS-1:0]     m_data,
    output logic [2:0]                m_slot,
    output logic [DBG_ADDR_WIDTH-1:0] m_addr
);

    localparam int SLOTS  = DATA_WIDTH / ENTRY_BITS;
    localparam int PACKED = SLOTS * ENTRY_BITS;
    localparam int LAT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_STOP,
        S_SETTLE,
        S_READ,
        S_WAIT,
        S_UNPACK,
        S_FIN
    } state_t;

    state_t state, next_state;

    logic [DBG_ADDR_WIDTH-1:0] addr_q;
    logic [DBG_ADDR_WIDTH:0]   remain_q;
    logic [PACKED-1:0]         word_q;
    logic [2:0]                slot_q;
    logic [LAT_W-1:0]          lat_q;
    logic [DBG_ADDR_WIDTH+3:0] sent_q;

    logic [ENTRY_BITS-1:0] cand;
    logic                  skip;
    logic                  slot_last;
    logic                  advance;
    logic                  handshake;

    // Upper word bits beyond the last whole entry carry no trace data.
    if (PACKED < DATA_WIDTH) begin : g_pad
        logic unused_hi;
        assign unused_hi = ^dbg_dout[DATA_WIDTH-1:PACKED];
    end

    always_comb begin
        cand = '0;
        for (int unsigned i = 0; i < SLOTS; i++) begin
            if (slot_q == 3'(i)) begin
                cand = word_q[i*ENTRY_BITS +: ENTRY_BITS];
            end
        end
    end

    assign skip      = (SKIP_EMPTY != 0) && (cand[ENTRY_BITS-1 -: 2] == 2'b00);
    assign slot_last = (slot_q == 3'(SLOTS - 1));
    assign handshake = (state == S_UNPACK) && !skip && m_ready;
    assign advance   = (state == S_UNPACK) && (skip || m_ready);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = (word_count == '0) ? S_FIN : S_STOP;
            S_STOP:   next_state = S_SETTLE;
            S_SETTLE: next_state = S_READ;
            S_READ:   next_state = S_WAIT;
            S_WAIT:   if (lat_q == '0) next_state = S_UNPACK;
            S_UNPACK: begin
                if (advance && slot_last) begin
                    next_state = (remain_q == (DBG_ADDR_WIDTH+1)'(1)) ? S_FIN : S_READ;
                end
            end
            S_FIN:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if ((state != S_IDLE) && abort) begin
            next_state = S_IDLE;
        end
    end

    // An entry taken in the same cycle as abort still counts: downstream has it.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q   <= '0;
            remain_q <= '0;
            word_q   <= '0;
            slot_q   <= '0;
            lat_q    <= '0;
            sent_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr_q   <= start_addr;
                        remain_q <= word_count;
                        sent_q   <= '0;
                    end
                end
                S_READ: lat_q <= LAT_W'(RD_LAT - 1);
                S_WAIT: begin
                    if (lat_q == '0) begin
                        word_q <= dbg_dout[PACKED-1:0];
                        slot_q <= '0;
                    end else begin
                        lat_q <= lat_q - 1'b1;
                    end
                end
                S_UNPACK: begin
                    if (handshake) begin
                        sent_q <= sent_q + 1'b1;
                    end
                    if (advance) begin
                        if (slot_last) begin
                            addr_q   <= addr_q + 1'b1;
                            remain_q <= remain_q - 1'b1;
                            slot_q   <= '0;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        busy          = (state != S_IDLE);
        done          = (state == S_FIN);
        dbg_cmd_valid = (state == S_STOP);
        dbg_cmd       = 6'h01;
        dbg_re        = (state == S_READ);
        dbg_addr      = (state == S_READ) ? addr_q : '0;
        m_valid       = (state == S_UNPACK) && !skip;
        m_data        = m_valid ? cand : '0;
        m_slot        = m_valid ? slot_q : '0;
        m_addr        = m_valid ? addr_q : '0;
        entries_sent  = sent_q;
    end

endmodule
